// File: rtl/trap_sequencer_pkg.sv
// Shared constants, state encoding and mstatus helpers
// for the machine-mode trap sequencer.
package trap_sequencer_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MS_MIE    = 3;
  localparam int MS_MPIE   = 7;
  localparam int MS_MPP_LO = 11;
  localparam int MS_MPP_HI = 12;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_T_RD_ST    = 4'd1,
    S_T_WR_ST    = 4'd2,
    S_T_WR_EPC   = 4'd3,
    S_T_WR_CAUSE = 4'd4,
    S_T_WR_TVAL  = 4'd5,
    S_T_RD_VEC   = 4'd6,
    S_M_RD_ST    = 4'd7,
    S_M_WR_ST    = 4'd8,
    S_M_RD_EPC   = 4'd9,
    S_REDIRECT   = 4'd10
  } state_t;

  function automatic logic [31:0] trap_mstatus(
    input logic [31:0] s
  );
    logic [31:0] r;
    r = s;
    r[MS_MPIE] = s[MS_MIE];
    r[MS_MIE] = 1'b0;
    r[MS_MPP_HI:MS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mret_mstatus(
    input logic [31:0] s
  );
    logic [31:0] r;
    r = s;
    r[MS_MIE] = s[MS_MPIE];
    r[MS_MPIE] = 1'b1;
    r[MS_MPP_HI:MS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Request, CSR-port and redirect bundle between the
// trap sequencer (master) and core/CSR file (slave).
interface trap_sequencer_if;
  logic        exc_valid;
  logic [31:0] exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret_valid;
  logic        exc_ready;
  logic        busy;
  logic [11:0] csr_addr;
  logic        csr_ren;
  logic        csr_wen;
  logic [31:0] csr_wd;
  logic [31:0] csr_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    input  exc_valid, exc_cause, exc_pc,
    input  exc_tval, mret_valid, csr_rd,
    output exc_ready, busy, csr_addr,
    output csr_ren, csr_wen, csr_wd,
    output redirect_valid, redirect_pc
  );

  modport slave (
    output exc_valid, exc_cause, exc_pc,
    output exc_tval, mret_valid, csr_rd,
    input  exc_ready, busy, csr_addr,
    input  csr_ren, csr_wen, csr_wd,
    input  redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_sequencer_vector_calc.sv
// Trap target from mtvec and mcause; only mode 01
// with an interrupt cause is vectored.
module trap_vector_calc (
  input  logic [31:0] mtvec,
  input  logic [31:0] cause,
  output logic [31:0] target
);
  logic [31:0] base;
  logic [31:0] off;
  logic        vect;

  assign base = {mtvec[31:2], 2'b00};
  assign off  = 32'(cause[30:0]) << 2;
  assign vect = (mtvec[1:0] == 2'b01) && cause[31];
  assign target = vect ? base + off : base;
endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer driving
// the CSR file one access per cycle.
module trap_sequencer
  import trap_sequencer_pkg::*;
(
  input logic       clock,
  input logic       reset,
  trap_sequencer_if.master bus
);
  state_t      state_q, state_d;
  logic [31:0] cause_q, pc_q, tval_q, rdata_q;
  logic        mret_q;
  logic [31:0] vec_target, target;

  trap_vector_calc u_vec (
    .mtvec  (rdata_q),
    .cause  (cause_q),
    .target (vec_target)
  );

  // rdata_q holds mepc on the MRET path
  assign target = mret_q ?
    {rdata_q[31:2], 2'b00} : vec_target;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cause_q <= '0;
      pc_q    <= '0;
      tval_q  <= '0;
      rdata_q <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) begin
        if (bus.exc_valid) begin
          cause_q <= bus.exc_cause;
          pc_q    <= bus.exc_pc;
          tval_q  <= bus.exc_tval;
          mret_q  <= 1'b0;
        end else if (bus.mret_valid) begin
          mret_q  <= 1'b1;
        end
      end
      if (bus.csr_ren) rdata_q <= bus.csr_rd;
    end
  end

  always_comb begin
    state_d            = state_q;
    bus.exc_ready      = 1'b0;
    bus.busy           = 1'b1;
    bus.csr_addr       = '0;
    bus.csr_ren        = 1'b0;
    bus.csr_wen        = 1'b0;
    bus.csr_wd         = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    unique case (state_q)
      S_IDLE: begin
        bus.exc_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.exc_valid)
          state_d = S_T_RD_ST;
        else if (bus.mret_valid)
          state_d = S_M_RD_ST;
      end
      S_T_RD_ST: begin
        bus.csr_ren  = 1'b1;
        bus.csr_addr = CSR_MSTATUS;
        state_d      = S_T_WR_ST;
      end
      S_T_WR_ST: begin
        bus.csr_wen  = 1'b1;
        bus.csr_addr = CSR_MSTATUS;
        bus.csr_wd   = trap_mstatus(rdata_q);
        state_d      = S_T_WR_EPC;
      end
      S_T_WR_EPC: begin
        bus.csr_wen  = 1'b1;
        bus.csr_addr = CSR_MEPC;
        bus.csr_wd   = {pc_q[31:2], 2'b00};
        state_d      = S_T_WR_CAUSE;
      end
      S_T_WR_CAUSE: begin
        bus.csr_wen  = 1'b1;
        bus.csr_addr = CSR_MCAUSE;
        bus.csr_wd   = cause_q;
        state_d      = S_T_WR_TVAL;
      end
      S_T_WR_TVAL: begin
        bus.csr_wen  = 1'b1;
        bus.csr_addr = CSR_MTVAL;
        bus.csr_wd   = tval_q;
        state_d      = S_T_RD_VEC;
      end
      S_T_RD_VEC: begin
        bus.csr_ren  = 1'b1;
        bus.csr_addr = CSR_MTVEC;
        state_d      = S_REDIRECT;
      end
      S_M_RD_ST: begin
        bus.csr_ren  = 1'b1;
        bus.csr_addr = CSR_MSTATUS;
        state_d      = S_M_WR_ST;
      end
      S_M_WR_ST: begin
        bus.csr_wen  = 1'b1;
        bus.csr_addr = CSR_MSTATUS;
        bus.csr_wd   = mret_mstatus(rdata_q);
        state_d      = S_M_RD_EPC;
      end
      S_M_RD_EPC: begin
        bus.csr_ren  = 1'b1;
        bus.csr_addr = CSR_MEPC;
        state_d      = S_REDIRECT;
      end
      S_REDIRECT: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; ports are named clock and reset.
REQ-002 Ports SHALL be, clock first:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- exc_valid  in  1  exception or interrupt request
- exc_cause  in  32  mcause value; bit31 = interrupt
- exc_pc  in  32  faulting or interrupted PC
- exc_tval  in  32  trap value
- mret_valid  in  1  MRET retire request
- exc_ready  out  1  request accepted this cycle (IDLE only)
- busy  out  1  sequence in progress; pipeline stalls
- csr_addr  out  12  CSR file address
- csr_ren  out  1  CSR read enable
- csr_wen  out  1  CSR write enable
- csr_wd  out  32  CSR write data
- csr_rd  in  32  CSR read data (combinational; 0 unless ren=1 and wen=0)
- redirect_valid  out  1  one-cycle PC redirect pulse
- redirect_pc  out  32  redirect target

Function
REQ-003 exc_ready SHALL be 1 only in IDLE; busy SHALL be 1 in every state other than IDLE.
REQ-004 In IDLE, exc_valid=1 SHALL latch cause, pc and tval and enter T_RD_ST; if exc_valid=0 and mret_valid=1, the block SHALL enter M_RD_ST; if both are 1, the exception SHALL win and mret_valid SHALL be ignored.
REQ-005 The trap path SHALL be T_RD_ST -> T_WR_ST -> T_WR_EPC -> T_WR_CAUSE -> T_WR_TVAL -> T_RD_VEC -> REDIRECT -> IDLE, one cycle per state.
REQ-006 The MRET path SHALL be M_RD_ST -> M_WR_ST -> M_RD_EPC -> REDIRECT -> IDLE.
REQ-007 In read states, the block SHALL drive csr_ren=1, csr_wen=0 and csr_addr (mstatus 0x300, mtvec 0x305, mepc 0x341), and SHALL capture csr_rd into an internal register at the closing edge.
REQ-008 In write states, the block SHALL drive csr_wen=1, csr_ren=0, csr_addr and csr_wd. In all other states csr_ren, csr_wen, csr_addr and csr_wd SHALL be 0.
REQ-009 T_WR_ST SHALL write mstatus as the captured value with these changes, all other bits unchanged:
- MPIE[7] = old MIE[3]
- MIE[3] = 0
- MPP[12:11] = 2'b11
REQ-010 M_WR_ST SHALL write mstatus with these changes, all other bits unchanged:
- MIE[3] = old MPIE[7]
- MPIE[7] = 1
- MPP = 2'b11
REQ-011 T_WR_EPC SHALL write mepc (0x341) = latched pc with bits[1:0] cleared.
REQ-012 T_WR_CAUSE SHALL write mcause (0x342) = latched cause; T_WR_TVAL SHALL write mtval (0x343) = latched tval.
REQ-013 The trap target SHALL be computed from the captured mtvec:
- base = {mtvec[31:2], 2'b00}
- if mtvec[1:0]=01 and cause[31]=1: target = base + 4*cause[30:0], truncated to 32 bits
- otherwise (including modes 10 and 11): target = base
REQ-014 The MRET target SHALL be the captured mepc with bits[1:0] cleared.
REQ-015 In REDIRECT, redirect_valid SHALL be 1 for exactly one cycle with redirect_pc = target; redirect_pc SHALL be 0 in all other states.
REQ-016 Latency SHALL be fixed: for a request accepted at edge 0, a trap pulses redirect_valid in cycle 7 and an MRET in cycle 4; the block SHALL return to IDLE the following cycle.
REQ-017 While busy, exc_valid and mret_valid SHALL be ignored, and latched values SHALL NOT change.
REQ-018 The block SHALL accept a new request in the first IDLE cycle after REDIRECT, so back-to-back traps are allowed.

Reset
REQ-019 While reset=1 at an edge, the state SHALL become IDLE and all latched registers SHALL become 0.
REQ-020 From the following cycle after reset, outputs SHALL be: exc_ready=1, and all other outputs 0.
REQ-021 Reset mid-sequence SHALL abort with no further CSR writes; CSR writes already made SHALL NOT be rolled back.

Structure
REQ-022 The following SHALL live in shared constants.vh:
- CSR addresses 0x300, 0x305, 0x341, 0x342, 0x343
- mstatus bit positions MIE, MPIE, MPP
- state encodings
REQ-023 Target computation SHALL be a combinational sub-module, trap_vector_calc (inputs mtvec, cause; output target).

Verification
REQ-024 Trap, direct mode: mtvec=0x00000100, mstatus=0x00000008, exc_pc=0x80000046, cause=2, tval=0xDEADBEEF. Required:
- mstatus=0x00001880
- mepc=0x80000044
- mcause=2
- mtval=0xDEADBEEF
- redirect_pc=0x00000100 in cycle 7
REQ-025 Trap, vectored interrupt: mtvec=0x00000101, cause=0x80000007 -> redirect_pc=0x0000011C.
REQ-026 MRET: mstatus=0x00001880, mepc=0x80000044. Required:
- mstatus=0x00001888
- redirect_pc=0x80000044 in cycle 4
REQ-027 Simultaneous exc_valid=1 and mret_valid=1 in IDLE -> trap sequence runs and no MRET write occurs; requests held during busy are not re-accepted until IDLE.
REQ-028 reset=1 asserted in T_WR_EPC -> no mcause/mtval writes, no redirect_valid, exc_ready=1 after reset.
REQ-029 Trap with mtvec mode 11 (mtvec=0x00000203) -> redirect_pc=0x00000200.
